// File: rtl/uart_bus_bridge.sv
// UART command decoder acting as a single-word bus initiator (debug / boot loader master).
// Define UART_BRIDGE_TIMEOUT_EN to abort partial frames after TIMEOUT_CYC idle cycles.
module uart_bus_bridge #(
  parameter int unsigned CLK_DIV     = 434,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        rx,
  output logic        tx,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy
);

  localparam logic [15:0] DivLast  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HalfLast = 16'(CLK_DIV / 2 - 1);
  localparam logic [7:0]  OpWrite  = 8'h57;
  localparam logic [7:0]  OpRead   = 8'h52;
  localparam logic [7:0]  AckByte  = 8'h4B;

  if (CLK_DIV < 8 || CLK_DIV > 65535 || TIMEOUT_CYC > 1048575) begin : g_bad_cfg
    $error("uart_bus_bridge: parameter out of range");
  end

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {SIdle, SAddr, SData, SBus, SResp} cmd_state_e;

  rx_state_e   rx_state_q, rx_state_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;

  cmd_state_e  state_q, state_d;
  logic        op_wr_q, op_wr_d, strobe_q, strobe_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [1:0]  fcnt_q, fcnt_d, resp_left_q, resp_left_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, resp_q, resp_d;

  logic        tx_q, tx_active_q, tx_load, tx_done;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic [9:0]  tx_shift_q;
  logic [7:0]  tx_byte;
  logic        timeout;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // A line already back high at mid-start is a glitch, not a frame.
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == DivLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_bit_d   = '0;
            rx_state_d = RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      RxStop: begin
        if (rx_cnt_q == DivLast) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          rx_valid_d = rx_sync_q;
          rx_ferr_d  = !rx_sync_q;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam logic [19:0] ToLast = 20'(TIMEOUT_CYC);
  logic [19:0] to_cnt_q;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      to_cnt_q <= '0;
    end else if ((state_q != SAddr && state_q != SData) || rx_valid_q) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q != ToLast) begin
      to_cnt_q <= to_cnt_q + 20'd1;
    end
  end

  assign timeout = (to_cnt_q == ToLast);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= SIdle;
      op_wr_q     <= 1'b0;
      strobe_q    <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      fcnt_q      <= '0;
      resp_left_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      strobe_q    <= strobe_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      fcnt_q      <= fcnt_d;
      resp_left_q <= resp_left_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    strobe_d    = strobe_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    fcnt_d      = fcnt_q;
    resp_left_d = resp_left_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_d      = resp_q;
    tx_load     = 1'b0;
    tx_byte     = resp_q[31:24];
    case (state_q)
      SIdle: begin
        if (rx_valid_q && (rx_shift_q == OpWrite || rx_shift_q == OpRead)) begin
          op_wr_d = (rx_shift_q == OpWrite);
          fcnt_d  = '0;
          state_d = SAddr;
        end
      end
      SAddr: begin
        if (rx_ferr_q || timeout) begin
          state_d = SIdle;
        end else if (rx_valid_q) begin
          addr_d = {addr_q[23:0], rx_shift_q};
          fcnt_d = fcnt_q + 2'd1;
          if (fcnt_q == 2'd3) state_d = op_wr_q ? SData : SBus;
        end
      end
      SData: begin
        if (rx_ferr_q || timeout) begin
          state_d = SIdle;
        end else if (rx_valid_q) begin
          wdata_d = {wdata_q[23:0], rx_shift_q};
          fcnt_d  = fcnt_q + 2'd1;
          if (fcnt_q == 2'd3) state_d = SBus;
        end
      end
      SBus: begin
        // First cycle arms the strobe; second cycle is the strobe cycle itself.
        if (!strobe_q) begin
          rd_d     = !op_wr_q;
          wr_d     = op_wr_q;
          strobe_d = 1'b1;
        end else begin
          strobe_d = 1'b0;
          tx_load  = 1'b1;
          state_d  = SResp;
          if (op_wr_q) begin
            tx_byte     = AckByte;
            resp_left_d = '0;
          end else begin
            tx_byte     = rdata[31:24];
            resp_d      = {rdata[23:0], 8'h00};
            resp_left_d = 2'd3;
          end
        end
      end
      SResp: begin
        if (tx_done) begin
          if (resp_left_q != 2'd0) begin
            tx_load     = 1'b1;
            resp_d      = {resp_q[23:0], 8'h00};
            resp_left_d = resp_left_q - 2'd1;
          end else begin
            state_d = SIdle;
          end
        end
      end
      default: state_d = SIdle;
    endcase
  end

  // A load in the last stop-bit cycle chains the next byte with no idle gap.
  assign tx_done = tx_active_q && (tx_bit_q == 4'd9) && (tx_cnt_q == DivLast);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      tx_q        <= 1'b1;
      tx_active_q <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '1;
    end else if (tx_load) begin
      tx_q        <= 1'b0;
      tx_active_q <= 1'b1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= {1'b1, tx_byte, 1'b0};
    end else if (tx_active_q) begin
      if (tx_cnt_q == DivLast) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_active_q <= 1'b0;
          tx_q        <= 1'b1;
        end else begin
          tx_bit_q   <= tx_bit_q + 4'd1;
          tx_shift_q <= tx_shift_q >> 1;
          tx_q       <= tx_shift_q[1];
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 16'd1;
      end
    end
  end

  assign tx    = tx_q;
  assign rd    = rd_q;
  assign wr    = wr_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign busy  = (state_q != SIdle);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed self-checking bench for uart_bus_bridge: write, read, junk/framing, glitch, reset
// mid-response and (with UART_BRIDGE_TIMEOUT_EN) inter-byte timeout.
module tb_uart_bus_bridge;

  localparam int Div = 16;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic        rx = 1'b1;
  logic        tx, rd, wr, busy;
  logic [31:0] addr, wdata, rdata;
  logic [31:0] rd_value = 32'h0000_001F;

  // Read data is only meaningful in the rd cycle; anything else returns a marker.
  assign rdata = rd ? rd_value : 32'hA5A5_A5A5;

  uart_bus_bridge #(
    .CLK_DIV    (Div),
    .TIMEOUT_CYC(5000)
  ) dut (
    .CLK    (CLK),
    .Reset_n(Reset_n),
    .rx     (rx),
    .tx     (tx),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .busy   (busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          rd_cnt = 0, wr_cnt = 0, rd_cyc = 0, wr_cyc = 0;
  logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0;

  initial forever begin
    @(negedge CLK);
    if (rd) begin
      rd_cnt++;
      rd_addr = addr;
      rd_cyc  = cyc;
    end
    if (wr) begin
      wr_cnt++;
      wr_addr = addr;
      wr_data = wdata;
      wr_cyc  = cyc;
    end
  end

  logic [7:0] tx_bytes[$];
  int         tx_starts[$];

  initial forever begin : tx_mon
    int         st;
    logic [7:0] b;
    @(negedge CLK);
    if (Reset_n && !tx) begin
      st = cyc;
      repeat (Div / 2) @(negedge CLK);
      if (!tx) begin
        for (int i = 0; i < 8; i++) begin
          repeat (Div) @(negedge CLK);
          b[i] = tx;
        end
        repeat (Div) @(negedge CLK);
        tx_bytes.push_back(b);
        tx_starts.push_back(st);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge CLK);
    rx = 1'b0;
    repeat (Div) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Div) @(negedge CLK);
    end
    rx = stop;
    repeat (Div) @(negedge CLK);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52, 1'b1);
    send_word(a);
  endtask

  task automatic wait_tx(input string tag, input int n);
    int k = 0;
    while (tx_bytes.size() < n && k < 60 * Div) begin
      @(negedge CLK);
      k++;
    end
    check(tag, tx_bytes.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 60 * Div) begin
      @(negedge CLK);
      k++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic clear_tx();
    tx_bytes.delete();
    tx_starts.delete();
  endtask

  task automatic check_read_resp(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] want;
      want = {24'd0, exp[8*(3-i) +: 8]};
      check($sformatf("%s_byte%0d", tag, i), {24'd0, tx_bytes[i]}, want);
    end
  endtask

  initial begin
    repeat (200000) @(posedge CLK);
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_rd", {31'd0, rd}, 32'd0);
    check("rst_wr", {31'd0, wr}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    Reset_n = 1'b1;
    repeat (5) @(negedge CLK);

    // Write 0x41 to 0x40000018, expect 'K'.
    send_byte(8'h57, 1'b1);
    check("wr_busy_rise", {31'd0, busy}, 32'd1);
    send_word(32'h4000_0018);
    send_word(32'h0000_0041);
    wait_tx("wr_resp_len", 1);
    wait_idle("wr_idle");
    check("wr_count", wr_cnt, 1);
    check("wr_no_rd", rd_cnt, 0);
    check("wr_addr", wr_addr, 32'h4000_0018);
    check("wr_data", wr_data, 32'h0000_0041);
    check("wr_resp", {24'd0, tx_bytes[0]}, 32'h4B);
    check("wr_tx_lat", tx_starts[0] - wr_cyc, 1);
    check("addr_held", addr, 32'h4000_0018);
    clear_tx();

    // Read 0x40000020 returning 0x1F, four bytes back to back.
    send_read(32'h4000_0020);
    wait_tx("rd_resp_len", 4);
    wait_idle("rd_idle");
    check("rd_count", rd_cnt, 1);
    check("rd_no_wr", wr_cnt, 1);
    check("rd_addr", rd_addr, 32'h4000_0020);
    check_read_resp("rd", 32'h0000_001F);
    for (int i = 1; i < 4; i++) check($sformatf("rd_gap%0d", i), tx_starts[i] - tx_starts[i-1],
                                      10 * Div);
    check("rd_tx_lat", tx_starts[0] - rd_cyc, 1);
    clear_tx();

    // Junk byte, then opcode followed by a framing error.
    send_byte(8'hAA, 1'b1);
    repeat (4) @(negedge CLK);
    check("junk_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h57, 1'b1);
    check("fr_busy_rise", {31'd0, busy}, 32'd1);
    send_byte(8'h00, 1'b0);
    repeat (Div) @(negedge CLK);
    check("fr_busy_drop", {31'd0, busy}, 32'd0);
    check("fr_no_strobe", rd_cnt + wr_cnt, 2);
    check("fr_no_resp", tx_bytes.size(), 0);
    send_byte(8'h57, 1'b1);
    send_word(32'h0000_0004);
    send_word(32'h1234_5678);
    wait_tx("fr_wr_resp_len", 1);
    wait_idle("fr_wr_idle");
    check("fr_wr_count", wr_cnt, 2);
    check("fr_wr_addr", wr_addr, 32'h0000_0004);
    check("fr_wr_data", wr_data, 32'h1234_5678);
    check("fr_wr_resp", {24'd0, tx_bytes[0]}, 32'h4B);
    clear_tx();

    // Quarter-bit glitch in the middle of a read frame must not insert a byte.
    rd_value = 32'hC35A_817E;
    send_byte(8'h52, 1'b1);
    @(negedge CLK);
    rx = 1'b0;
    repeat (Div / 4) @(negedge CLK);
    rx = 1'b1;
    repeat (2 * Div) @(negedge CLK);
    check("gl_busy", {31'd0, busy}, 32'd1);
    send_word(32'h4000_0024);
    wait_tx("gl_resp_len", 4);
    wait_idle("gl_idle");
    check("gl_rd_count", rd_cnt, 2);
    check("gl_rd_addr", rd_addr, 32'h4000_0024);
    check_read_resp("gl", 32'hC35A_817E);
    clear_tx();

    // Reset during the second response byte.
    send_read(32'h4000_0028);
    wait_tx("rst_first_byte", 1);
    repeat (3 * Div) @(negedge CLK);
    Reset_n = 1'b0;
    #1;
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge CLK);
    Reset_n = 1'b1;
    repeat (20 * Div) @(negedge CLK);
    clear_tx();
    rd_value = 32'h0BAD_F00D;
    send_read(32'h4000_002C);
    wait_tx("post_rst_len", 4);
    wait_idle("post_rst_idle");
    check("post_rst_rd_count", rd_cnt, 4);
    check("post_rst_addr", rd_addr, 32'h4000_002C);
    check("post_rst_no_wr", wr_cnt, 2);
    check_read_resp("post_rst", 32'h0BAD_F00D);
    clear_tx();

`ifdef UART_BRIDGE_TIMEOUT_EN
    // Partial write abandoned by timeout; the following read is decoded cleanly.
    send_byte(8'h57, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (6000) @(negedge CLK);
    check("to_busy", {31'd0, busy}, 32'd0);
    rd_value = 32'h0000_001F;
    send_read(32'h4000_001C);
    wait_tx("to_resp_len", 4);
    wait_idle("to_idle");
    check("to_rd_count", rd_cnt, 5);
    check("to_rd_addr", rd_addr, 32'h4000_001C);
    check("to_no_wr", wr_cnt, 2);
    clear_tx();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

UART-to-bus initiator: decodes framed commands arriving on a serial RX line and issues single-word `rd`/`wr` transactions on the CPU peripheral/memory bus, i.e. the initiator end of the bus that the memory-mapped UART unit answers as a responder. It returns read data and write acknowledges over its own TX line. It sits beside the CPU as a second bus master for debug and boot loading. External arbitration grants it the bus while `busy`=1.

## Interface
- `CLK_DIV`, 434: CLK cycles per UART bit; legal range 8..65535.
- `TIMEOUT_CYC`, 1000000: inter-byte timeout in CLK cycles. Used only when `UART_BRIDGE_TIMEOUT_EN` is defined.
- `CLK` in 1: system clock, all logic on posedge.
- `Reset_n` in 1: reset, asynchronous, active-low; clock `CLK`.
- `rx` in 1: serial input, idle high, 8N1, LSB first; asynchronous to `CLK`.
- `tx` out 1: serial output, idle high, 8N1, LSB first.
- `rd` out 1: one-cycle read strobe.
- `wr` out 1: one-cycle write strobe.
- `addr` out 32: bus address, held from strobe until next command.
- `wdata` out 32: write data, held like `addr`.
- `rdata` in 32: read data, valid combinationally in the cycle `rd`=1.
- `busy` out 1: high from first command byte accepted until last response stop bit ends.

## Operation
- RX front end:
  - `rx` passes through a 2-FF synchronizer (reset value 1).
  - A falling edge in RX_IDLE starts a bit counter.
  - At `CLK_DIV/2` the line is re-sampled; if it is high, this is a false start and RX returns to RX_IDLE.
  - The 8 data bits are sampled at `CLK_DIV` intervals from that midpoint. The stop bit is sampled one interval after bit 7.
  - Stop=0 is a framing error: the byte is discarded and the command FSM aborts to S_IDLE.
- Command frames, multibyte fields MSB first:
  - Write: `0x57` ('W'), A3 A2 A1 A0, D3 D2 D1 D0.
  - Read: `0x52` ('R'), A3 A2 A1 A0.
- Command FSM states: S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP.
  - S_IDLE: byte 0x57 or 0x52 latches the opcode and goes to S_ADDR. Any other byte is dropped silently and the FSM stays in S_IDLE.
  - S_ADDR: shifts 4 bytes into `addr`. Then a write goes to S_DATA and a read goes to S_BUS.
  - S_DATA: shifts 4 bytes into `wdata`, then goes to S_BUS.
  - S_BUS: asserts `wr` or `rd` for exactly one cycle. On a read, captures `rdata` into the response register in that same cycle. Then goes to S_RESP.
  - S_RESP: transmits the response. Write response: 1 byte, 0x4B ('K'). Read response: 4 bytes, MSB first. Then returns to S_IDLE.
- Bytes received during S_BUS or S_RESP are discarded; the bridge is half-duplex at command level.
- TX: start bit (0), 8 data bits, stop bit (1), each held exactly `CLK_DIV` cycles. Back-to-back response bytes carry no idle gap.
- Reset values: `tx`=1, `rd`=0, `wr`=0, `addr`=0, `wdata`=0, `busy`=0, FSM in S_IDLE.
- Reset asserted mid-frame or mid-response: all state clears immediately, `tx` goes to 1 asynchronously, and no strobe is issued.

## Timing
- A received byte is available to the FSM 1 cycle after its stop-bit sample (~9.5 bit times + 2 synchronizer cycles after the start edge).
- S_BUS is entered the cycle after the last frame byte is accepted.
- The strobe is asserted in the cycle after S_BUS is entered and lasts exactly 1 cycle. `addr`/`wdata` are stable ≥1 cycle before it.
- The TX start bit begins the cycle after the strobe.
- Response duration: write = 10×`CLK_DIV` cycles; read = 40×`CLK_DIV` cycles.
- `busy` rises the cycle after the opcode byte is accepted. It falls the cycle after the final stop bit completes.
- Bit and timeout counters are 16 and 20 bits wide. They wrap only through explicit reload to 0, never by overflow.

## Configuration
- `UART_BRIDGE_TIMEOUT_EN` defined:
  - A counter restarts at each accepted byte while the FSM is in S_ADDR or S_DATA.
  - When it reaches `TIMEOUT_CYC`, the FSM aborts to S_IDLE: no strobe, no response, `busy`→0 the next cycle.
- Not defined: no timeout logic is present; a partial frame waits indefinitely.

## Test plan
- Write: send 57 40 00 00 18 00 00 00 41 → one `wr` pulse with `addr`=0x40000018, `wdata`=0x00000041; then `tx` sends 0x4B.
- Read: send 52 40 00 00 20, bench drives `rdata`=0x0000001F in the `rd` cycle → exactly one `rd` pulse; `tx` sends 00 00 00 1F with no inter-byte gap.
- Junk/framing: send 0xAA, then 0x57 followed by a byte with stop bit 0 → no strobe, `busy` returns 0; a following valid write completes normally.
- Glitch: 0.25-bit low pulse on `rx` → no byte is received and FSM state is unchanged.
- Reset mid-response: assert `Reset_n`=0 during the second read-response byte → `tx`=1, `busy`=0 immediately; after release, a new read succeeds.
- Timeout (`UART_BRIDGE_TIMEOUT_EN`, `TIMEOUT_CYC`=5000): send 57 40 00, then idle 6000 cycles, then 52 40 00 00 1C → only `rd` with `addr`=0x4000001C, never `wr`.
